uart_rx_port: RTL

UART_RX_PORT -- requirements
Module: uart_rx_port

---
 rtl/uart_defs.sv | 23 ++
 rtl/rx_fifo.sv | 65 ++++++
 rtl/uart_rx_port.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_defs.sv
// Shared definitions for the UART receive port.
// Register map, status bit positions and receiver states.
package uart_defs;

   localparam logic [31:0] RXDATA_OFS = 32'h0;
   localparam logic [31:0] STATUS_OFS = 32'h4;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVR   = 2;
   localparam int ST_FERR  = 3;

   localparam int DEF_CLKS_PER_BIT = 434;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO for received bytes.
// Simultaneous push and pop are both honoured, even when full.
module rx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_FULL);
   assign count = count_q;
   assign dout  = mem_q[rptr_q];

   // a pop frees the slot the same-cycle push needs
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= din;
   end

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped UART receiver with byte FIFO.
// Two-cycle bus handshake; RXDATA read pops, STATUS is W1C.
module uart_rx_port
   import uart_defs::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_3010,
   parameter int          CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int          FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        irst,
   input  logic [31:0] MADDR,
   inout  wire  [31:0] MDATA,
   input  logic [3:0]  MBE,
   input  logic        MEN,
   input  logic        MRW,
   inout  wire         MWAIT,
   input  logic        usb_rx,
   output logic        rd_empty
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   logic            sync1_q, sync2_q, prev_q;

   rx_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            push_q, push_d;
   logic            ferr_set;

   logic            ovr_q, ovr_d;
   logic            ferr_q, ferr_d;

   logic            acc_q, acc_d;
   logic            rd_q, rd_d;
   logic [31:0]     rdata_q, rdata_d;

   logic            is_rx, is_st, sel, first;
   logic            pop, clr_ovr, clr_ferr;
   logic [7:0]      fifo_dout;
   logic            fifo_full, fifo_empty;
   logic [FCW-1:0]  fifo_count;
   logic            unused_ok;

   rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst_n (irst),
      .push  (push_q),
      .pop   (pop),
      .din   (shift_q),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign rd_empty = fifo_empty;

   always_ff @(posedge clk or negedge irst) begin
      if (!irst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= usb_rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      push_d   = 1'b0;
      ferr_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (prev_q && !sync2_q) begin
               state_d = START;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         START: begin
            if (cnt_q == MID) begin
               cnt_d   = '0;
               state_d = sync2_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (sync2_q) begin
                  push_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_d  = WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_IDLE: begin
            if (sync2_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge irst) begin
      if (!irst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         push_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         push_q  <= push_d;
      end
   end

   assign is_rx = (MADDR == BASE_ADDR + RXDATA_OFS);
   assign is_st = (MADDR == BASE_ADDR + STATUS_OFS);
   assign sel   = irst && MEN && (is_rx || is_st);
   assign first = sel && !acc_q;

   assign pop      = first && MRW && is_rx && !fifo_empty;
   assign clr_ovr  = first && !MRW && is_st && MDATA[ST_OVR];
   assign clr_ferr = first && !MRW && is_st && MDATA[ST_FERR];

   // a set in the same cycle as a clear wins
   assign ovr_d  = (push_q && fifo_full && !pop) || (ovr_q && !clr_ovr);
   assign ferr_d = ferr_set || (ferr_q && !clr_ferr);

   assign acc_d = first;
   assign rd_d  = first && MRW;

   always_comb begin
      rdata_d = rdata_q;
      unique case (1'b1)
         first && is_rx:
            rdata_d = fifo_empty ? 32'h0 : {23'b0, 1'b1, fifo_dout};
         first && is_st:
            rdata_d = {28'b0, ferr_q, ovr_q, fifo_full, fifo_empty};
         default:
            rdata_d = rdata_q;
      endcase
   end

   always_ff @(posedge clk or negedge irst) begin
      if (!irst) begin
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         acc_q   <= 1'b0;
         rd_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
         acc_q   <= acc_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
      end
   end

   assign MWAIT = (first || acc_q) ? first : 1'bz;
   assign MDATA = (acc_q && rd_q) ? rdata_q : 32'bz;

   assign unused_ok = ^{MBE, MDATA[31:4], MDATA[1:0], fifo_count};

endmodule
